// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the icache read handshake and
// produces the IF/ID load/flush controls, absorbing stalls, redirects and halt.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic [31:0] instruction,
    output logic [31:0] imemaddr_IF,
    output logic [31:0] npc_IF,
    output logic        enable_IF_ID,
    output logic        flush_IF_ID,
    output logic [31:0] fetch_count,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] count_q, count_d;
    logic        ren_s, enable_s, flush_s;
    logic [31:0] target_s;

    assign target_s = {redirect_addr[31:2], 2'b00};

    // State, PC, pending-target and perf-counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            pend_q  <= 32'h0000_0000;
            count_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    // Next-state and IF/ID control; pc only moves on an ihit cycle
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        count_d  = count_q;
        ren_s    = 1'b1;
        enable_s = 1'b0;
        flush_s  = 1'b0;
        case (state_q)
            FETCH: begin
                if (halt) begin
                    state_d = HALT;
                    flush_s = 1'b1;
                end else if (redirect_valid) begin
                    flush_s = 1'b1;
                    if (ihit) begin
                        pc_d = target_s;
                    end else begin
                        pend_d  = target_s;
                        state_d = DRAIN;
                    end
                end else if (ihit && !stall) begin
                    enable_s = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    count_d  = count_q + 32'd1;
                end else begin
                    pc_d = pc_q;
                end
            end
            DRAIN: begin
                // The outstanding miss is wrong-path; its word is dropped on return
                if (halt) begin
                    state_d = HALT;
                    flush_s = 1'b1;
                end else if (redirect_valid) begin
                    pend_d  = target_s;
                    flush_s = 1'b1;
                    if (ihit) begin
                        pc_d    = target_s;
                        state_d = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (ihit) begin
                    pc_d    = pend_q;
                    state_d = FETCH;
                end else begin
                    state_d = DRAIN;
                end
            end
            HALT: begin
                ren_s = 1'b0;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imemREN      = ren_s;
    assign imemaddr     = pc_q;
    assign imemaddr_IF  = pc_q;
    assign npc_IF       = pc_q + 32'd4;
    assign instruction  = imemload;
    assign enable_IF_ID = enable_s & nRST;
    assign flush_IF_ID  = flush_s & nRST;
    assign fetch_count  = count_q;
    assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: two instances (reset PC 0 and 0xFFFF_FFFC)
// driven by directed then random stimulus, checked against a behavioural model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        halt = 1'b0;

    logic        ren_a, en_a, fl_a, hlt_a, ren_b, en_b, fl_b, hlt_b;
    logic [31:0] addr_a, instr_a, addrif_a, npc_a, cnt_a;
    logic [31:0] addr_b, instr_b, addrif_b, npc_b, cnt_b;

    localparam logic [31:0] RST_A = 32'h0000_0000;
    localparam logic [31:0] RST_B = 32'hFFFF_FFFC;

    fetch_unit #(.PC_RESET(RST_A)) u_a (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(ren_a), .imemaddr(addr_a), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
        .instruction(instr_a), .imemaddr_IF(addrif_a), .npc_IF(npc_a),
        .enable_IF_ID(en_a), .flush_IF_ID(fl_a), .fetch_count(cnt_a), .halted(hlt_a)
    );

    fetch_unit #(.PC_RESET(RST_B)) u_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(ren_b), .imemaddr(addr_b), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
        .instruction(instr_b), .imemaddr_IF(addrif_b), .npc_IF(npc_b),
        .enable_IF_ID(en_b), .flush_IF_ID(fl_b), .fetch_count(cnt_b), .halted(hlt_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pend;
        logic [31:0] cnt;
        bit          wrong_path;
        bit          stopped;
    } mdl_t;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic [31:0] npc;
        logic [31:0] instr;
        logic [31:0] cnt;
        logic        en;
        logic        fl;
        logic        hlt;
    } exp_t;

    mdl_t m_a, m_b;
    exp_t q_a[$];
    exp_t q_b[$];
    int   vectors = 0;
    int   miscompares = 0;

    // What the fetch stage should present this cycle, and where it goes next
    function automatic void step(input mdl_t mi, input logic [31:0] rpc, output mdl_t mo,
                                 output exp_t e);
        logic [31:0] tgt;
        mo = mi;
        if (!nRST) begin
            mo.pc = rpc; mo.pend = 32'h0; mo.cnt = 32'h0;
            mo.wrong_path = 1'b0; mo.stopped = 1'b0;
        end
        e.ren = !mo.stopped;
        e.addr = mo.pc;
        e.npc = mo.pc + 32'd4;
        e.instr = imemload;
        e.cnt = mo.cnt;
        e.hlt = mo.stopped;
        e.en = 1'b0;
        e.fl = 1'b0;
        if (!nRST) return;
        tgt = redirect_addr & 32'hFFFF_FFFC;
        if (mo.stopped) begin
        end else if (halt) begin
            e.fl = 1'b1;
            mo.stopped = 1'b1;
        end else if (redirect_valid) begin
            e.fl = 1'b1;
            if (ihit) begin
                mo.pc = tgt;
                mo.wrong_path = 1'b0;
            end else begin
                mo.pend = tgt;
                mo.wrong_path = 1'b1;
            end
        end else if (mo.wrong_path) begin
            if (ihit) begin
                mo.pc = mo.pend;
                mo.wrong_path = 1'b0;
            end
        end else if (ihit && !stall) begin
            e.en = 1'b1;
            mo.pc = mo.pc + 32'd4;
            mo.cnt = mo.cnt + 32'd1;
        end
    endfunction

    task automatic cyc(input bit n, input bit h, input bit s, input bit rv,
                       input logic [31:0] ra, input bit hl);
        exp_t ea, eb;
        @(posedge CLK);
        #1;
        nRST = n; ihit = h; stall = s; redirect_valid = rv;
        redirect_addr = ra; halt = hl; imemload = $urandom;
        #1;
        step(m_a, RST_A, m_a, ea);
        step(m_b, RST_B, m_b, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set, checked mid-cycle
    always @(negedge CLK) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            vectors++;
            chk("a.imemREN", {31'h0, ren_a}, {31'h0, e.ren});
            chk("a.imemaddr", addr_a, e.addr);
            chk("a.imemaddr_IF", addrif_a, e.addr);
            chk("a.npc_IF", npc_a, e.npc);
            chk("a.instruction", instr_a, e.instr);
            chk("a.enable", {31'h0, en_a}, {31'h0, e.en});
            chk("a.flush", {31'h0, fl_a}, {31'h0, e.fl});
            chk("a.fetch_count", cnt_a, e.cnt);
            chk("a.halted", {31'h0, hlt_a}, {31'h0, e.hlt});
            chk("a.en_and_flush", {31'h0, en_a & fl_a}, 32'h0);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            vectors++;
            chk("b.imemREN", {31'h0, ren_b}, {31'h0, e.ren});
            chk("b.imemaddr", addr_b, e.addr);
            chk("b.npc_IF", npc_b, e.npc);
            chk("b.enable", {31'h0, en_b}, {31'h0, e.en});
            chk("b.flush", {31'h0, fl_b}, {31'h0, e.fl});
            chk("b.fetch_count", cnt_b, e.cnt);
            chk("b.halted", {31'h0, hlt_b}, {31'h0, e.hlt});
        end
    end

    initial begin
        m_a = '{pc: RST_A, pend: 32'h0, cnt: 32'h0, wrong_path: 1'b0, stopped: 1'b0};
        m_b = '{pc: RST_B, pend: 32'h0, cnt: 32'h0, wrong_path: 1'b0, stopped: 1'b0};
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        // Back-to-back hits: 0,4 then stall at 0x8
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        // Redirect with hit at 0x10, then back to 0x20 and redirect during a miss
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        // Halt beats stall and redirect, then sticks until reset
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b1);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 249) != 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom,
                ($urandom_range(0, 299) == 0));
        end
        @(negedge CLK);
        #1;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending expected 0", q_a.size(), q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS datapath. It owns the PC, drives the instruction-cache read handshake (imemREN/imemaddr → ihit/imemload), and is the producer side of the IF/ID pipeline register. It generates the instruction word, its address and PC+4, plus the enable_IF_ID and flush_IF_ID controls that register consumes. It absorbs stalls from the hazard unit, branch/jump redirects from later stages, and halt.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  icache: imemload valid for current imemaddr this cycle.
- imemload  in  32  icache read data.
- imemREN  out  1  icache read request.
- imemaddr  out  32  icache address (= PC register).
- stall  in  1  hazard unit: IF/ID must hold; PC must not advance.
- redirect_valid  in  1  later stage resolved taken branch/jump this cycle.
- redirect_addr  in  32  redirect target; bits [1:0] ignored (forced 0).
- halt  in  1  HALT retired; stop fetching.
- instruction  out  32  to IF/ID: = imemload (combinational).
- imemaddr_IF  out  32  to IF/ID: address of instruction (= PC).
- npc_IF  out  32  to IF/ID: PC + 4, modulo 2^32.
- enable_IF_ID  out  1  IF/ID load enable.
- flush_IF_ID  out  1  IF/ID flush (loads bubble).
- fetch_count  out  32  instructions delivered to IF/ID (perf counter).
- halted  out  1  high in HALT state.

## Operation
- Registers: pc (32), pend (32, pending redirect target), state {FETCH, DRAIN, HALT}, fetch_count (32).
- Cache rule: once imemREN is asserted with an address, imemaddr stays constant until the cycle ihit is seen. The fetch unit never changes pc on a cycle without ihit, except via HALT.
- Priority per cycle: halt > redirect_valid > stall > normal.
- FETCH: imemREN=1.
  - halt: → HALT; enable=0, flush=1.
  - redirect_valid & ihit: flush=1, enable=0, pc ← redirect_addr & ~3, stay FETCH.
  - redirect_valid & !ihit: flush=1, enable=0, pend ← redirect_addr & ~3, → DRAIN.
  - ihit & !stall: enable=1, pc ← pc+4, fetch_count ← fetch_count+1.
  - ihit & stall: enable=0, pc held; same address re-requested next cycle.
  - !ihit: enable=0, flush=0, hold.
- DRAIN (wrong-path miss outstanding): imemREN=1, imemaddr=old pc, enable=0.
  - halt: → HALT, flush=1.
  - redirect_valid: pend ← new target (newest wins), flush=1; if same-cycle ihit, pc ← new target and → FETCH.
  - ihit (no redirect): returned word discarded, flush=0, pc ← pend, → FETCH.
  - !ihit: hold.
- HALT: imemREN=0, enable=0, flush=0, halted=1. Sticky until nRST.
- stall never blocks a flush; flush_IF_ID and enable_IF_ID are never both 1.
- fetch_count wraps 0xFFFF_FFFF → 0. PC+4 wraps 0xFFFF_FFFC → 0.

## Timing
- Reset (nRST low, async): pc=PC_RESET, pend=0, state=FETCH, fetch_count=0. Outputs while low: imemREN=1, imemaddr=imemaddr_IF=PC_RESET, npc_IF=PC_RESET+4, halted=0. enable_IF_ID and flush_IF_ID are forced 0 while nRST is low.
- Reset deassertion mid-miss: restart at PC_RESET in FETCH; stale ihit from cache is not expected (cache shares reset).
- enable/flush/instruction are combinational from state and inputs in the ihit cycle. IF/ID captures on the same rising edge that advances pc.
- Hit latency: one instruction per cycle on back-to-back ihit with stall=0.
- Redirect penalty: 0 extra cycles if ihit coincides; otherwise remaining miss cycles + 1.
- All state, pc, pend, and fetch_count updates occur on the rising edge of CLK.

## Test plan
- Reset, ihit=1 every cycle, stall=0: imemaddr sequence 0,4,8,12. enable_IF_ID=1 each cycle. fetch_count=4 after 4 edges.
- Stall: stall=1 at pc=0x8 for 3 cycles with ihit=1: imemaddr stays 0x8, enable=0, fetch_count frozen. Release → 0xC next edge.
- Redirect with hit: pc=0x10, ihit=1, redirect_valid=1, redirect_addr=0x40: flush=1, enable=0. Next imemaddr=0x40; fetch_count unchanged.
- Redirect during miss: pc=0x20, ihit=0, redirect to 0x103 (→0x100): flush=1 and state DRAIN, imemaddr holds 0x20. A second redirect to 0x200 overwrites pend. On ihit, enable=0 and the next imemaddr=0x200.
- Halt: halt=1 with stall=1 and redirect_valid=1: flush=1, then imemREN=0, halted=1 forever. Async nRST mid-HALT returns imemaddr=PC_RESET and fetch_count=0.
- Wrap: PC_RESET=0xFFFF_FFFC, ihit=1: npc_IF=0, next imemaddr=0. Redirect_addr=0xFFFF_FFFF loads 0xFFFF_FFFC.
